// File: rtl/sobel_conv_if.sv
// Handshake/data bundle between the window-gathering stage and the Sobel engine.
// With SOBEL_DIR_EN defined the bundle also carries the quantised gradient direction.
interface sobel_conv_if;
    logic        rst_conv;
    logic [23:0] row1;
    logic [23:0] row2;
    logic [23:0] row3;
    logic [7:0]  conv_result;
    logic        conv_ready;
`ifdef SOBEL_DIR_EN
    logic [1:0]  conv_dir;
`endif

    modport master (
        output rst_conv, row1, row2, row3,
`ifdef SOBEL_DIR_EN
        input  conv_dir,
`endif
        input  conv_result, conv_ready
    );

    modport slave (
        input  rst_conv, row1, row2, row3,
`ifdef SOBEL_DIR_EN
        output conv_dir,
`endif
        output conv_result, conv_ready
    );
endinterface

// File: rtl/sobel_conv.sv
// 3x3 Sobel engine: captures a window, accumulates Gx/Gy one kernel row per cycle,
// then outputs min((|Gx|+|Gy|)>>SHIFT, SAT_MAX). Optional macro SOBEL_DIR_EN adds conv_dir.
module sobel_conv #(
    parameter int SHIFT   = 0,
    parameter int SAT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    sobel_conv_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC0 = 3'd1;
    localparam logic [2:0] S_ACC1 = 3'd2;
    localparam logic [2:0] S_ACC2 = 3'd3;
    localparam logic [2:0] S_MAG  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [10:0] SAT_LIM = 11'(SAT_MAX);

    logic [2:0]         state;
    logic [7:0]         pix_p0 [9];
    logic signed [11:0] gx_p1;
    logic signed [11:0] gy_p1;
    logic [7:0]         res_p2;
    logic               vld_p2;
    logic               start;
    logic [10:0]        ax;
    logic [10:0]        ay;
    logic [10:0]        mag;

    function automatic logic signed [11:0] sx(input logic [7:0] p);
        return signed'({4'b0000, p});
    endfunction

    function automatic logic [10:0] abs11(input logic signed [11:0] v);
        return 11'(v[11] ? -v : v);
    endfunction

    function automatic logic [7:0] scale_sat(input logic [10:0] m);
        logic [10:0] s;
        s = m >> SHIFT;
        return (s > SAT_LIM) ? SAT_LIM[7:0] : s[7:0];
    endfunction

`ifdef SOBEL_DIR_EN
    function automatic logic [1:0] grad_dir(input logic signed [11:0] gx,
                                            input logic signed [11:0] gy);
        logic [11:0] a_x;
        logic [11:0] a_y;
        a_x = {1'b0, abs11(gx)};
        a_y = {1'b0, abs11(gy)};
        if (a_x >= (a_y << 1))      return 2'd0;
        else if (a_y >= (a_x << 1)) return 2'd1;
        else if (gx[11] == gy[11])  return 2'd2;
        else                        return 2'd3;
    endfunction

    logic [1:0] dir_p2;
`endif

    assign start = !bus.rst_conv && (state == S_IDLE);
    assign ax    = abs11(gx_p1);
    assign ay    = abs11(gy_p1);
    assign mag   = ax + ay;

    // Stage p0: window capture, only on the start edge
    always_ff @(posedge clk) begin
        if (!rst && start) begin
            pix_p0[0] <= bus.row1[23:16];
            pix_p0[1] <= bus.row1[15:8];
            pix_p0[2] <= bus.row1[7:0];
            pix_p0[3] <= bus.row2[23:16];
            pix_p0[4] <= bus.row2[15:8];
            pix_p0[5] <= bus.row2[7:0];
            pix_p0[6] <= bus.row3[23:16];
            pix_p0[7] <= bus.row3[15:8];
            pix_p0[8] <= bus.row3[7:0];
        end
    end

    // Stages p1/p2: row-serial accumulation, then magnitude and saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            gx_p1  <= '0;
            gy_p1  <= '0;
            res_p2 <= '0;
            vld_p2 <= 1'b0;
`ifdef SOBEL_DIR_EN
            dir_p2 <= '0;
`endif
        end else if (bus.rst_conv) begin
            state  <= S_IDLE;
            vld_p2 <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    gx_p1 <= '0;
                    gy_p1 <= '0;
                    state <= S_ACC0;
                end
                S_ACC0: begin
                    gx_p1 <= gx_p1 - sx(pix_p0[0]) + sx(pix_p0[2]);
                    gy_p1 <= gy_p1 - sx(pix_p0[0]) - (sx(pix_p0[1]) <<< 1) - sx(pix_p0[2]);
                    state <= S_ACC1;
                end
                S_ACC1: begin
                    gx_p1 <= gx_p1 - (sx(pix_p0[3]) <<< 1) + (sx(pix_p0[5]) <<< 1);
                    state <= S_ACC2;
                end
                S_ACC2: begin
                    gx_p1 <= gx_p1 - sx(pix_p0[6]) + sx(pix_p0[8]);
                    gy_p1 <= gy_p1 + sx(pix_p0[6]) + (sx(pix_p0[7]) <<< 1) + sx(pix_p0[8]);
                    state <= S_MAG;
                end
                S_MAG: begin
                    res_p2 <= scale_sat(mag);
                    vld_p2 <= 1'b1;
`ifdef SOBEL_DIR_EN
                    dir_p2 <= grad_dir(gx_p1, gy_p1);
`endif
                    state  <= S_DONE;
                end
                S_DONE:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.conv_result = res_p2;
    assign bus.conv_ready  = vld_p2;
`ifdef SOBEL_DIR_EN
    assign bus.conv_dir    = dir_p2;
`endif

endmodule

// File: tb/tb_sobel_conv.sv
// Bench for sobel_conv: directed windows with literal expectations plus randomized
// traffic, checked every cycle against a behavioural Sobel model (two parameter sets).
module tb_sobel_conv;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sobel_conv_if b0 ();
    sobel_conv_if b1 ();

    assign b1.rst_conv = b0.rst_conv;
    assign b1.row1     = b0.row1;
    assign b1.row2     = b0.row2;
    assign b1.row3     = b0.row3;

    sobel_conv dut0 (.clk(clk), .rst(rst), .bus(b0));
    sobel_conv #(.SHIFT(2), .SAT_MAX(200)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference, straight from the kernel definitions
    function automatic void sobel_ref(input logic [23:0] r1, input logic [23:0] r2,
                                      input logic [23:0] r3, output int gx, output int gy);
        int p[9];
        p[0] = int'(r1[23:16]); p[1] = int'(r1[15:8]); p[2] = int'(r1[7:0]);
        p[3] = int'(r2[23:16]); p[4] = int'(r2[15:8]); p[5] = int'(r2[7:0]);
        p[6] = int'(r3[23:16]); p[7] = int'(r3[15:8]); p[8] = int'(r3[7:0]);
        gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
        gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int res_of(input int gx, input int gy, input int sh, input int sm);
        int r;
        r = (iabs(gx) + iabs(gy)) >> sh;
        return (r > sm) ? sm : r;
    endfunction

    function automatic int dir_of(input int gx, input int gy);
        if (iabs(gx) >= 2 * iabs(gy))      return 0;
        else if (iabs(gy) >= 2 * iabs(gx)) return 1;
        else if ((gx < 0) == (gy < 0))     return 2;
        else                               return 3;
    endfunction

    // Model: ph 0 = idle, 1..4 = clocks since capture, 5 = holding a result
    int m_ph, m_gx, m_gy, m_res0, m_res1, m_dir, m_rdy;
    initial begin
        m_ph = 0; m_gx = 0; m_gy = 0; m_res0 = 0; m_res1 = 0; m_dir = 0; m_rdy = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_rdy = 0; m_res0 = 0; m_res1 = 0; m_dir = 0;
        end else if (b0.rst_conv) begin
            m_ph = 0; m_rdy = 0;
        end else if (m_ph == 0) begin
            sobel_ref(b0.row1, b0.row2, b0.row3, m_gx, m_gy);
            m_ph = 1;
        end else if (m_ph < 4) begin
            m_ph = m_ph + 1;
        end else if (m_ph == 4) begin
            m_res0 = res_of(m_gx, m_gy, 0, 255);
            m_res1 = res_of(m_gx, m_gy, 2, 200);
            m_dir  = dir_of(m_gx, m_gy);
            m_rdy  = 1;
            m_ph   = 5;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("ready_s0", int'(b0.conv_ready), m_rdy);
        chk("result_s0", int'(b0.conv_result), m_res0);
        chk("ready_s2", int'(b1.conv_ready), m_rdy);
        chk("result_s2", int'(b1.conv_result), m_res1);
`ifdef SOBEL_DIR_EN
        chk("dir_s0", int'(b0.conv_dir), m_dir);
        chk("dir_s2", int'(b1.conv_dir), m_dir);
`endif
    end

    function automatic logic [23:0] rnd_row();
        logic [23:0] r;
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 3) == 0)
                r[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            else
                r[i*8 +: 8] = 8'($urandom);
        end
        return r;
    endfunction

    task automatic run_window(input logic [23:0] r1, input logic [23:0] r2,
                              input logic [23:0] r3, input int exp_res,
                              input int exp_dir, input string nm);
        int n;
        @(negedge clk);
        b0.row1 = r1; b0.row2 = r2; b0.row3 = r3;
        b0.rst_conv = 1'b0;
        @(posedge clk);
        n = 99;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (b0.conv_ready) begin
                n = i;
                break;
            end
        end
        chk({nm, "_latency"}, n, 4);
        chk({nm, "_result"}, int'(b0.conv_result), exp_res);
`ifdef SOBEL_DIR_EN
        chk({nm, "_dir"}, int'(b0.conv_dir), exp_dir);
`else
        if (exp_dir < 0) chk({nm, "_dir_arg"}, exp_dir, 0);
`endif
    endtask

    task automatic rearm(input string nm);
        @(negedge clk);
        b0.rst_conv = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, "_rearm_ready"}, int'(b0.conv_ready), 0);
    endtask

    initial begin
        int gx, gy;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        b0.rst_conv = 1'b1;
        b0.row1 = '0; b0.row2 = '0; b0.row3 = '0;

        sobel_ref(24'h00050A, 24'h00050A, 24'h00050A, gx, gy);
        chk("model_gx", gx, 40);
        chk("model_sat_s2", res_of(1020, 0, 2, 200), 200);
        chk("model_dir_p2", dir_of(50, -50), 3);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_ready", int'(b0.conv_ready), 0);
        chk("reset_result", int'(b0.conv_result), 0);

        run_window(24'h646464, 24'h646464, 24'h646464, 0, 0, "flat");     rearm("flat");
        run_window(24'h00050A, 24'h00050A, 24'h00050A, 40, 0, "hedge");    rearm("hedge");
        run_window(24'h000000, 24'h000000, 24'h141414, 80, 1, "vedge");    rearm("vedge");
        run_window(24'h000000, 24'h000000, 24'h000032, 100, 2, "p8");      rearm("p8");
        run_window(24'h000032, 24'h000000, 24'h000000, 100, 3, "p2");      rearm("p2");
        run_window(24'h0000FF, 24'h0000FF, 24'h0000FF, 255, 0, "sat");     rearm("sat");

        // Abort while the engine sits in ACC1, then restart straight away
        @(negedge clk);
        b0.row1 = 24'hFF0000; b0.row2 = 24'hFF0000; b0.row3 = 24'hFF0000;
        b0.rst_conv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        b0.rst_conv = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", int'(b0.conv_ready), 0);
        run_window(24'h000000, 24'h000000, 24'h000032, 100, 2, "after_abort");

        // Result must hold in DONE regardless of row activity
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b0.row1 = rnd_row(); b0.row2 = rnd_row(); b0.row3 = rnd_row();
            @(posedge clk);
            #1;
            chk("hold_ready", int'(b0.conv_ready), 1);
            chk("hold_result", int'(b0.conv_result), 100);
        end
        rearm("hold");
        chk("rearm_keeps_result", int'(b0.conv_result), 100);

        // Synchronous reset in the middle of accumulation
        @(negedge clk);
        b0.rst_conv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_result", int'(b0.conv_result), 0);
        chk("midrst_ready", int'(b0.conv_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        b0.rst_conv = 1'b1;

        repeat (1500) begin
            @(negedge clk);
            b0.row1 = rnd_row(); b0.row2 = rnd_row(); b0.row3 = rnd_row();
            b0.rst_conv = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        b0.rst_conv = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
